riscv_axi_lite_ram: RTL
=======================

# riscv_axi_lite_ram

AXI4-Lite slave data memory that sits directly downstream of the pipeline's memory-stage AXI bridge and terminates the core's `M_AXI_*` bus. It serves the load and store traffic issued by the MEM stage from a word-organised, byte-writable RAM. It returns OKAY for in-range accesses and SLVERR for out-of-range accesses. Read and write channels run independent state machines, so one read and one write can be outstanding at the same time.

## Interface
- `ADDR_WIDTH`, default 10: word-index width. Memory holds 2^ADDR_WIDTH 32-bit words (4 KiB by default).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `S_AXI_AWADDR`  in  32  write address (byte address).
- `S_AXI_AWVALID`  in  1  write address valid.
- `S_AXI_AWREADY`  out  1  write address ready.
- `S_AXI_WDATA`  in  32  write data.
- `S_AXI_WSTRB`  in  4  byte strobes; bit i enables write of byte i (`WDATA[8i+7:8i]`).
- `S_AXI_WVALID`  in  1  write data valid.
- `S_AXI_WREADY`  out  1  write data ready.
- `S_AXI_BRESP`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- `S_AXI_BVALID`  out  1  write response valid.
- `S_AXI_BREADY`  in  1  write response ready.
- `S_AXI_ARADDR`  in  32  read address (byte address).
- `S_AXI_ARVALID`  in  1  read address valid.
- `S_AXI_ARREADY`  out  1  read address ready.
- `S_AXI_RDATA`  out  32  read data.
- `S_AXI_RRESP`  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- `S_AXI_RVALID`  out  1  read data valid.
- `S_AXI_RREADY`  in  1  read data ready.

## Operation
- **Address decode**
  - Word index = `addr[ADDR_WIDTH+1:2]`.
  - `addr[1:0]` is ignored; every access is treated as an aligned word access.
  - An access is in range when `addr[31:ADDR_WIDTH+2] == 0`.
- **Write FSM** (states W_IDLE, W_RESP)
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle. Each accepted channel is latched into a holding register with a "held" flag.
  - AWREADY = W_IDLE and AW not held. WREADY = W_IDLE and W not held.
  - At the edge where the second of the two handshakes completes (or both complete together), the FSM:
    - commits the write: each byte whose WSTRB bit is set is written; bytes with WSTRB=0 keep their value;
    - clears both held flags;
    - loads BRESP;
    - enters W_RESP.
  - Out-of-range writes modify nothing and return BRESP=2'b10. In-range writes return 2'b00.
  - In W_RESP, BVALID=1 and BRESP is stable until BVALID&&BREADY. At that edge the FSM returns to W_IDLE.
- **Read FSM** (states R_IDLE, R_DATA)
  - ARREADY = R_IDLE.
  - At the AR handshake edge, the addressed word (in range) or 32'h0 (out of range) is captured into the RDATA register, RRESP is set to 2'b00 or 2'b10, and the FSM enters R_DATA.
  - In R_DATA, RVALID=1 and RDATA/RRESP are stable until RVALID&&RREADY. At that edge the FSM returns to R_IDLE.
- **Read/write collision**: if a read capture and a write commit hit the same word on the same edge, the read returns the old data (read-before-write).
- **Memory contents**: not cleared by `rst`. Contents are undefined until written.

## Timing
- **Outputs during reset**: every output is registered. While `rst`=1 and on the first edge after it, AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=32'h0.
- **After reset**: AWREADY, WREADY and ARREADY rise in the first cycle after `rst` deasserts.
- **Write latency**: BVALID rises in the cycle after the completing AW/W handshake. AWREADY and WREADY are 0 from the cycle after their own handshake until the cycle after the B handshake.
- **Read latency**: RVALID rises in the cycle after the AR handshake. ARREADY is 0 from that cycle until the cycle after the R handshake.
- **Throughput**: with BREADY/RREADY held high, each channel completes one transaction every 2 cycles.
- **Reset mid-transaction**:
  - The FSMs return to idle and held AW/W data is discarded.
  - A pending BVALID or RVALID drops in the cycle after `rst` is sampled.
  - Writes already committed persist.
- **Validity of handshakes**: a handshake is only recognised when the corresponding ready is 1. VALID asserted while ready=0 is held off with no side effect.

## Test plan
- Reset, then AW+W in the same cycle (addr 0x10, data 0xDEADBEEF, WSTRB 4'hF) -> BVALID 1 cycle later with BRESP 00. Read 0x10 -> RVALID 1 cycle after AR, RDATA 0xDEADBEEF, RRESP 00.
- Word 0x40 holds 0xAABBCCDD. Present W (0x12345678, WSTRB 4'b0011) 3 cycles before AW -> WREADY drops after the W handshake, BVALID only after AW. Read 0x40 -> 0xAABB5678.
- Backpressure:
  - BREADY low for 5 cycles -> BVALID and BRESP held, AWREADY/WREADY stay 0.
  - RREADY low for 5 cycles -> RVALID held and RDATA stable.
  - Both channels return to ready 1 cycle after their handshake.
- Out of range with ADDR_WIDTH=10:
  - Write 0x00001000 (data 0xFFFFFFFF) -> BRESP 10, and word 0 (preloaded 0x0) remains 0x0.
  - Read 0x00001000 -> RDATA 0x0, RRESP 10.
- Collision: word 0x20 holds 0x11111111. Write 0x22222222 and read 0x20 complete on the same edge -> RDATA 0x11111111. A following read returns 0x22222222.
- Assert `rst` while BVALID=1 and RVALID=1 -> both 0 the next cycle. Readies return 1 the cycle after release. Reading the just-written address returns the committed data.

Source files
------------

// File: rtl/riscv_axi_lite_ram_if.sv
// AXI4-Lite bus bundle between the memory-stage bridge (master) and the data RAM (slave).
interface riscv_axi_lite_ram_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/riscv_axi_lite_ram.sv
// AXI4-Lite byte-writable word RAM with independent read and write state machines.
// All bus outputs are registered; out-of-range accesses answer SLVERR and touch nothing.
module riscv_axi_lite_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input logic                 clk,
  input logic                 rst,
  riscv_axi_lite_ram_if.slave axi
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [31:0] mem [WORDS];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_held, w_held, aw_held_d, w_held_d;
  logic [31:0]           aw_addr_q, w_data_q;
  logic [3:0]            w_strb_q;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic                  awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [31:0]           wr_addr, wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (ADDR_WIDTH + 2)) == 32'd0;
  endfunction

  assign aw_hs = awready_q & axi.S_AXI_AWVALID;
  assign w_hs  = wready_q  & axi.S_AXI_WVALID;
  assign b_hs  = bvalid_q  & axi.S_AXI_BREADY;
  assign ar_hs = arready_q & axi.S_AXI_ARVALID;
  assign r_hs  = rvalid_q  & axi.S_AXI_RREADY;

  // A channel not yet held is completing its handshake this edge, so take it from the bus.
  assign wr_addr = aw_held ? aw_addr_q : axi.S_AXI_AWADDR;
  assign wr_data = w_held  ? w_data_q  : axi.S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q  : axi.S_AXI_WSTRB;
  assign commit  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_idx      = wr_addr[ADDR_WIDTH+1:2];
  assign wr_in_range = in_range(wr_addr);
  assign rd_idx      = axi.S_AXI_ARADDR[ADDR_WIDTH+1:2];
  assign rd_in_range = in_range(axi.S_AXI_ARADDR);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (b_hs)   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held;
    w_held_d  = w_held;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs)  w_held_d  = 1'b1;
    end
    awready_d = (w_next == W_IDLE) & ~aw_held_d;
    wready_d  = (w_next == W_IDLE) & ~w_held_d;
    bvalid_d  = (w_next == W_RESP);
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      w_state   <= w_next;
      r_state   <= r_next;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (commit) bresp_q <= wr_in_range ? 2'b00 : 2'b10;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : 32'h0;
        rresp_q <= rd_in_range ? 2'b00 : 2'b10;
      end
    end
  end

  // Holding registers carry no reset: the held flags alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= axi.S_AXI_AWADDR;
    if (w_hs) begin
      w_data_q <= axi.S_AXI_WDATA;
      w_strb_q <= axi.S_AXI_WSTRB;
    end
  end

  // Same-edge read capture sees the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    if (commit && wr_in_range && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign axi.S_AXI_AWREADY = awready_q;
  assign axi.S_AXI_WREADY  = wready_q;
  assign axi.S_AXI_BVALID  = bvalid_q;
  assign axi.S_AXI_BRESP   = bresp_q;
  assign axi.S_AXI_ARREADY = arready_q;
  assign axi.S_AXI_RVALID  = rvalid_q;
  assign axi.S_AXI_RDATA   = rdata_q;
  assign axi.S_AXI_RRESP   = rresp_q;

endmodule
